mult8_seq_ctrl: RTL and testbench
=================================

MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 5: cycles after the multiplier load edge before mul_prod is final.
REQ-002 Parameter TAG_W, default 4: width of the request tag.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_a  input  8  unsigned multiplicand.
REQ-008 in_b  input  8  unsigned multiplier.
REQ-009 in_tag  input  TAG_W  request tag, returned with the result.
REQ-010 mul_a  output  8  multiplicand to the multiplier stage.
REQ-011 mul_b  output  8  multiplier operand to the multiplier stage.
REQ-012 mul_load  output  1  one-cycle load pulse to the multiplier stage.
REQ-013 mul_rst  output  1  active-high synchronous reset to the multiplier stage.
REQ-014 mul_prod  input  16  product from the multiplier stage.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_prod  output  16  captured product.
REQ-018 out_tag  output  TAG_W  tag of the captured product.
REQ-019 mismatch  output  1  sticky flag: a captured product differed from in_a*in_b.
REQ-020 done_cnt  output  16  count of completed output handshakes, wraps 0xFFFF->0.

Function
REQ-021 FSM states: MRST, IDLE, LOAD, WAIT, DONE; all state is held in registers.
REQ-022 MRST: mul_rst=1 for exactly one cycle after reset release, then go to IDLE.
REQ-023 IDLE: in_ready=1; on in_valid&&in_ready, register in_a, in_b and in_tag, then go to LOAD.
REQ-024 in_ready SHALL be 0 in every state except IDLE; in_valid while not ready is ignored, and operands are not sampled.
REQ-025 LOAD: mul_load=1 for exactly one cycle; mul_a/mul_b = registered operands; load cnt=MUL_LAT; go to WAIT.
REQ-026 mul_a/mul_b SHALL hold the registered operands from LOAD until the next accept; mul_load=0 in all other states.
REQ-027 WAIT: decrement cnt each cycle; at the edge where cnt==0, capture mul_prod into out_prod and the registered tag into out_tag, then go to DONE.
REQ-028 Latency: out_valid rises on the edge MUL_LAT+2 cycles after the accept edge (7 cycles at default).
REQ-029 DONE: out_valid=1; out_prod and out_tag stay stable until the handshake.
REQ-030 DONE: on out_ready=1, increment done_cnt and go to IDLE; in_ready stays 0 in that same cycle, so no same-cycle re-accept occurs.
REQ-031 DONE: out_ready=0 holds DONE indefinitely with no change to any output.
REQ-032 At the capture edge: if mul_prod != registered a * registered b (16-bit unsigned), set mismatch; mismatch clears only on reset.
REQ-033 cnt width is clog2(MUL_LAT+1); MUL_LAT=0 captures on the first WAIT cycle.
REQ-034 in_valid deasserting in states other than IDLE SHALL have no effect.

Reset
REQ-035 rst=0 SHALL immediately (asynchronously) force state=MRST, mul_rst=1, and all other outputs and registers to 0 (in_ready=0, out_valid=0, mismatch=0, done_cnt=0).
REQ-036 Reset asserted mid-operation (LOAD/WAIT/DONE) discards the in-flight request with no out_valid; the first accept after reset behaves as from power-up.

Verification
REQ-037 Reset release: mul_rst=1 for exactly 1 cycle, then in_ready=1; out_valid=0 and done_cnt=0 throughout.
REQ-038 Accept a=255, b=230, tag=3 with out_ready=1: single mul_load pulse; out_valid 7 cycles after accept; out_prod=58650, out_tag=3, mismatch=0, done_cnt=1.
REQ-039 Back-to-back requests 5x9, 150x100, 200x250: products 45, 15000, 50000 in order; exactly one idle cycle (in_ready=1) between DONE and the next accept.
REQ-040 Hold out_ready=0 for 20 cycles after 233x111: out_prod=25863 stable and in_ready=0 throughout; one handshake then increments done_cnt.
REQ-041 Force mul_prod to a wrong value during WAIT: mismatch=1 after capture and stays 1 through later correct operations until reset.
REQ-042 Assert rst=0 in WAIT of 7x211: outputs zero immediately; after release, 55x46 yields 2530 with done_cnt=1.

Source files
------------

// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl
// Sequencer for an external 8x8 multiplier stage. It accepts one request at a
// time, loads the operands into the multiplier, and waits MUL_LAT cycles. It
// then captures the product together with the request tag and holds the result
// until the consumer takes it. Every captured product is also checked against
// a local a*b. Any disagreement sets a sticky mismatch flag.
//
// Ports
//   clk       : single clock, all state updates on its rising edge
//   rst       : asynchronous active-low reset (0 = reset)
//   in_valid  : request present            in_ready  : block can accept
//   in_a/in_b : unsigned 8-bit operands    in_tag    : request tag
//   mul_a/b   : operands to multiplier     mul_load  : one-cycle load pulse
//   mul_rst   : sync reset to multiplier   mul_prod  : multiplier product
//   out_valid : result present             out_ready : consumer accepts
//   out_prod  : captured product           out_tag   : captured tag
//   mismatch  : sticky product-check flag  done_cnt  : completed handshakes
module mult8_seq_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  output logic             mul_load,
  output logic             mul_rst,
  input  logic [15:0]      mul_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_prod,
  output logic [TAG_W-1:0] out_tag,
  output logic             mismatch,
  output logic [15:0]      done_cnt
);

  // A zero-latency build still needs a one-bit counter to stay legal.
  localparam int CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [2:0] {MRST, IDLE, LOAD, WAIT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               capture;
  logic               handshake;
  logic [15:0]        ref_prod;

  assign accept    = (state == IDLE) && in_valid;
  assign capture   = (state == WAIT) && (cnt == '0);
  assign handshake = (state == DONE) && out_ready;
  assign ref_prod  = {8'h00, a_q} * {8'h00, b_q};

  // The operand registers drive the multiplier directly. They therefore stay
  // stable from LOAD until the next accept.
  assign mul_a = a_q;
  assign mul_b = b_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MRST;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      MRST: state_nxt = IDLE;
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = WAIT;
      WAIT: if (capture) state_nxt = DONE;
      DONE: if (handshake) state_nxt = IDLE;
      default: state_nxt = MRST;
    endcase
  end

  // Output decode. These outputs depend only on the state, so the handshake
  // cycle in DONE still shows in_ready=0.
  always_comb begin
    in_ready  = 1'b0;
    mul_load  = 1'b0;
    mul_rst   = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      MRST: mul_rst   = 1'b1;
      IDLE: in_ready  = 1'b1;
      LOAD: mul_load  = 1'b1;
      WAIT: ;
      DONE: out_valid = 1'b1;
      default: mul_rst = 1'b1;
    endcase
  end

  // Datapath: operand capture, latency counter, result capture, check flag
  // and the handshake counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      cnt      <= '0;
      out_prod <= '0;
      out_tag  <= '0;
      mismatch <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        tag_q <= in_tag;
      end
      if (state == LOAD) begin
        cnt <= CNT_W'(MUL_LAT);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        out_prod <= mul_prod;
        out_tag  <= tag_q;
        if (mul_prod != ref_prod) mismatch <= 1'b1;
      end
      if (handshake) done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl. It includes a behavioural
// multiplier stage whose product only becomes valid MUL_LAT cycles after the
// load edge. That stage can also be told to return a corrupted product.
module tb_mult8_seq_ctrl;

  localparam int MUL_LAT = 5;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             mul_load;
  logic             mul_rst;
  logic [15:0]      mul_prod;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_prod;
  logic [TAG_W-1:0] out_tag;
  logic             mismatch;
  logic [15:0]      done_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_done = 0;

  logic        force_bad = 1'b0;
  logic [15:0] model_pend = '0;
  int          model_lat = 0;

  mult8_seq_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load), .mul_rst(mul_rst),
    .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag),
    .mismatch(mismatch), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier stage model: the product reads as zero until the latency
  // has elapsed. This exposes a capture taken too early.
  always @(posedge clk) begin
    if (mul_rst) begin
      model_pend <= '0;
      model_lat  <= 0;
    end else if (mul_load) begin
      model_pend <= {8'h00, mul_a} * {8'h00, mul_b};
      model_lat  <= MUL_LAT;
    end else if (model_lat != 0) begin
      model_lat <= model_lat - 1;
    end
  end

  assign mul_prod = ((model_lat == 0) ? model_pend : 16'h0000) ^ (force_bad ? 16'h0100 : 16'h0000);

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    logic [15:0]      prod;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issues one request and waits until out_valid is seen. While the block is
  // busy, in_valid stays high with junk operands; the block must ignore them.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [TAG_W-1:0] tag,
                               output int lat, output int loads);
    int guard;
    int busy_ready;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ready_before_req", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    @(posedge clk); #1;
    in_a = a ^ 8'hA5;
    in_b = ~b;
    in_tag = ~tag;
    checkOutput("mul_a_load", mul_a, a);
    checkOutput("mul_b_load", mul_b, b);
    loads = int'(mul_load);
    busy_ready = int'(in_ready);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      loads += int'(mul_load);
      busy_ready += int'(in_ready);
    end
    in_valid = 1'b0;
    checkOutput("busy_in_ready", busy_ready, 0);
    checkOutput("mul_a_hold", mul_a, a);
    checkOutput("mul_b_hold", mul_b, b);
  endtask

  // Completes the handshake, with out_ready already high, and checks the idle cycle.
  task automatic checkHandshake();
    @(posedge clk); #1;
    exp_done++;
    checkOutput("done_cnt", done_cnt, exp_done);
    checkOutput("out_valid_after_hs", out_valid, 0);
    checkOutput("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int loads;

    vecs[0] = '{a: 8'd255, b: 8'd230, tag: 4'd3,  prod: 16'd58650};
    vecs[1] = '{a: 8'd5,   b: 8'd9,   tag: 4'd1,  prod: 16'd45};
    vecs[2] = '{a: 8'd150, b: 8'd100, tag: 4'd2,  prod: 16'd15000};
    vecs[3] = '{a: 8'd200, b: 8'd250, tag: 4'd4,  prod: 16'd50000};
    vecs[4] = '{a: 8'd0,   b: 8'd0,   tag: 4'd0,  prod: 16'd0};
    vecs[5] = '{a: 8'd255, b: 8'd255, tag: 4'd15, prod: 16'd65025};

    rst = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b1;

    // Reset values while reset is held.
    #2;
    checkOutput("rst_mul_rst", mul_rst, 1);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    checkOutput("rst_mismatch", mismatch, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mrst_mul_rst", mul_rst, 1);
    checkOutput("mrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    checkOutput("idle_mul_rst", mul_rst, 0);
    checkOutput("idle_in_ready", in_ready, 1);
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("idle_done_cnt", done_cnt, 0);

    // Back-to-back table vectors with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].tag, lat, loads);
      checkOutput("latency", lat, MUL_LAT + 2);
      checkOutput("load_pulses", loads, 1);
      checkOutput("out_prod", out_prod, vecs[i].prod);
      checkOutput("out_tag", out_tag, vecs[i].tag);
      checkOutput("mismatch_clean", mismatch, 0);
      checkHandshake();
    end

    // The consumer stalls for 20 cycles; the result must stay frozen.
    out_ready = 1'b0;
    applyStimulus(8'd233, 8'd111, 4'd6, lat, loads);
    checkOutput("hold_latency", lat, MUL_LAT + 2);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_a = 8'd1;
      in_b = 8'd1;
      @(posedge clk); #1;
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_out_prod", out_prod, 16'd25863);
      checkOutput("hold_out_tag", out_tag, 6);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_done_cnt", done_cnt, exp_done);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkHandshake();

    // A corrupted product sets the sticky flag, and a later correct operation does not clear it.
    force_bad = 1'b1;
    applyStimulus(8'd12, 8'd13, 4'd9, lat, loads);
    force_bad = 1'b0;
    checkOutput("bad_out_prod", out_prod, 16'd412);
    checkOutput("bad_mismatch", mismatch, 1);
    checkHandshake();
    applyStimulus(8'd7, 8'd8, 4'd10, lat, loads);
    checkOutput("after_bad_prod", out_prod, 16'd56);
    checkOutput("sticky_mismatch", mismatch, 1);
    checkHandshake();

    // Reset is asserted during WAIT of 7x211.
    in_valid = 1'b1;
    in_a = 8'd7;
    in_b = 8'd211;
    in_tag = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    exp_done = 0;
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_in_ready", in_ready, 0);
    checkOutput("abort_mul_rst", mul_rst, 1);
    checkOutput("abort_mul_load", mul_load, 0);
    checkOutput("abort_mismatch", mismatch, 0);
    checkOutput("abort_done_cnt", done_cnt, 0);
    checkOutput("abort_out_prod", out_prod, 0);
    checkOutput("abort_mul_a", mul_a, 0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rerst_in_ready", in_ready, 1);
    checkOutput("rerst_out_valid", out_valid, 0);
    applyStimulus(8'd55, 8'd46, 4'd11, lat, loads);
    checkOutput("rerst_latency", lat, MUL_LAT + 2);
    checkOutput("rerst_out_prod", out_prod, 16'd2530);
    checkOutput("rerst_out_tag", out_tag, 11);
    checkOutput("rerst_mismatch", mismatch, 0);
    checkHandshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
